axi4s_framer_esc: RTL and testbench



---
 rtl/axi4s_framer_esc.sv | 173 +++++++++++++++++
 tb/tb_axi4s_framer_esc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_framer_esc.sv
// Byte-stream framer with escape stuffing.
//
// Wraps each AXI4-Stream packet in START_BYTE ... STOP_BYTE. When ESC_EN is set, any payload
// byte equal to a control byte is sent as ESC_BYTE followed by (byte ^ ESC_XOR). The output is
// a single registered slot with full back-pressure.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   target_t{valid,ready,data,last}   payload byte stream in
//   initiator_t{valid,ready,data}     framed byte stream out
//   frame_count            frames whose STOP byte was accepted downstream
//   esc_count              escape sequences inserted
//   busy                   high from START emission until STOP accepted downstream
module axi4s_framer_esc #(
    parameter logic [7:0]  START_BYTE = 8'h7D,
    parameter logic [7:0]  STOP_BYTE  = 8'h7E,
    parameter logic [7:0]  ESC_BYTE   = 8'h7C,
    parameter logic [7:0]  ESC_XOR    = 8'h20,
    parameter bit          ESC_EN     = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             target_tvalid,
    output logic             target_tready,
    input  logic [7:0]       target_tdata,
    input  logic             target_tlast,
    output logic             initiator_tvalid,
    input  logic             initiator_tready,
    output logic [7:0]       initiator_tdata,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] esc_count,
    output logic             busy
);

    if (START_BYTE == STOP_BYTE || START_BYTE == ESC_BYTE || STOP_BYTE == ESC_BYTE) begin : gen_bad_delims
        $fatal(1, "axi4s_framer_esc: START_BYTE, STOP_BYTE and ESC_BYTE must be distinct");
    end

    typedef enum logic [1:0] {StIdle, StData, StEsc2, StStop} state_e;

    state_e             state_q, state_d;
    logic               tvalid_q, tvalid_d;
    logic [7:0]         tdata_q, tdata_d;
    logic [7:0]         hold_q, hold_d;
    logic               hold_last_q, hold_last_d;
    logic               stop_loaded_q, stop_loaded_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   esc_q, esc_d;

    logic               slot_free;
    logic               out_hs;
    logic               need_esc;
    logic               load;
    logic [7:0]         load_byte;

    assign slot_free = !tvalid_q || initiator_tready;
    assign out_hs    = tvalid_q && initiator_tready;
    assign need_esc  = ESC_EN && (target_tdata == START_BYTE || target_tdata == STOP_BYTE ||
                                  target_tdata == ESC_BYTE);

    assign target_tready    = (state_q == StData) && slot_free;
    assign initiator_tvalid = tvalid_q;
    assign initiator_tdata  = tdata_q;
    assign frame_count      = frame_q;
    assign esc_count        = esc_q;
    assign busy             = busy_q;

    always_comb begin
        state_d       = state_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        hold_d        = hold_q;
        hold_last_d   = hold_last_q;
        stop_loaded_d = stop_loaded_q;
        busy_d        = busy_q;
        frame_d       = frame_q;
        esc_d         = esc_q;
        load          = 1'b0;
        load_byte     = 8'h00;

        unique case (state_q)
            StIdle: begin
                // START is emitted without consuming the first payload byte.
                if (target_tvalid && slot_free) begin
                    load      = 1'b1;
                    load_byte = START_BYTE;
                    busy_d    = 1'b1;
                    state_d   = StData;
                end
            end
            StData: begin
                if (target_tvalid && target_tready) begin
                    load = 1'b1;
                    if (need_esc) begin
                        load_byte   = ESC_BYTE;
                        hold_d      = target_tdata ^ ESC_XOR;
                        hold_last_d = target_tlast;
                        esc_d       = esc_q + CNT_W'(1);
                        state_d     = StEsc2;
                    end else begin
                        load_byte = target_tdata;
                        if (target_tlast) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StEsc2: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = hold_q;
                    state_d   = hold_last_q ? StStop : StData;
                end
            end
            StStop: begin
                if (!stop_loaded_q) begin
                    if (slot_free) begin
                        load          = 1'b1;
                        load_byte     = STOP_BYTE;
                        stop_loaded_d = 1'b1;
                    end
                end else if (out_hs) begin
                    // STOP accepted; the next frame's START may reload the slot this same cycle.
                    frame_d       = frame_q + CNT_W'(1);
                    busy_d        = 1'b0;
                    stop_loaded_d = 1'b0;
                    state_d       = StIdle;
                    if (target_tvalid) begin
                        load      = 1'b1;
                        load_byte = START_BYTE;
                        busy_d    = 1'b1;
                        state_d   = StData;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = load_byte;
        end else if (out_hs) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            tvalid_q      <= 1'b0;
            tdata_q       <= 8'h00;
            hold_q        <= 8'h00;
            hold_last_q   <= 1'b0;
            stop_loaded_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_q       <= '0;
            esc_q         <= '0;
        end else begin
            state_q       <= state_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            hold_q        <= hold_d;
            hold_last_q   <= hold_last_d;
            stop_loaded_q <= stop_loaded_d;
            busy_q        <= busy_d;
            frame_q       <= frame_d;
            esc_q         <= esc_d;
        end
    end

endmodule

// File: tb/tb_axi4s_framer_esc.sv
// Bench for axi4s_framer_esc: directed vector table, random packets against a byte-expansion
// model, and a mid-frame reset sequence. dut0 escapes, dut1 has escaping disabled.
module tb_axi4s_framer_esc;

    localparam logic [7:0] START = 8'h7D;
    localparam logic [7:0] STOP  = 8'h7E;
    localparam logic [7:0] ESC   = 8'h7C;
    localparam logic [7:0] XORM  = 8'h20;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic       tv, tl, ir, sel;
    logic [7:0] td;

    logic        d0_tvalid, d0_tready, d0_ivalid, d0_busy;
    logic        d1_tvalid, d1_tready, d1_ivalid, d1_busy;
    logic [7:0]  d0_idata, d1_idata;
    logic [15:0] d0_fc, d0_ec, d1_fc, d1_ec;

    assign d0_tvalid = tv && !sel;
    assign d1_tvalid = tv && sel;

    logic        ttready, ivalid, dbusy;
    logic [7:0]  idata;
    logic [15:0] fcnt, ecnt;
    assign ttready = sel ? d1_tready : d0_tready;
    assign ivalid  = sel ? d1_ivalid : d0_ivalid;
    assign idata   = sel ? d1_idata  : d0_idata;
    assign dbusy   = sel ? d1_busy   : d0_busy;
    assign fcnt    = sel ? d1_fc     : d0_fc;
    assign ecnt    = sel ? d1_ec     : d0_ec;

    axi4s_framer_esc u_dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .target_tvalid(d0_tvalid), .target_tready(d0_tready),
        .target_tdata(td), .target_tlast(tl),
        .initiator_tvalid(d0_ivalid), .initiator_tready(ir), .initiator_tdata(d0_idata),
        .frame_count(d0_fc), .esc_count(d0_ec), .busy(d0_busy)
    );

    axi4s_framer_esc #(.ESC_EN(1'b0)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .target_tvalid(d1_tvalid), .target_tready(d1_tready),
        .target_tdata(td), .target_tlast(tl),
        .initiator_tvalid(d1_ivalid), .initiator_tready(ir), .initiator_tdata(d1_idata),
        .frame_count(d1_fc), .esc_count(d1_ec), .busy(d1_busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int         sel;
        int         rdy;
        int         n_in;
        logic [7:0] din [4];
        logic [3:0] lst;
        int         n_out;
        logic [7:0] dout [10];
        int         esc;
        int         frm;
    } vec_t;

    beat_t      src_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         exp_frm [2];
    int         exp_esc [2];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 5))
            0:       return START;
            1:       return STOP;
            2:       return ESC;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Drive src_q into the selected DUT and collect output bytes until `limit` are seen.
    // rdy_mode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready and valid gaps.
    task automatic run_stream(input int rdy_mode, input int limit);
        int         cyc = 0;
        int         first_out = -1;
        int         last_out = -1;
        int         first_pop = -1;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        got_q.delete();
        while (got_q.size() < limit && cyc < 2000) begin
            @(negedge aclk);
            case (rdy_mode)
                0:       ir = 1'b1;
                1:       ir = (cyc % 3 == 0);
                default: ir = ($urandom_range(0, 1) == 1);
            endcase
            if (src_q.size() > 0 && (rdy_mode != 2 || $urandom_range(0, 3) != 0)) begin
                tv = 1'b1;
                td = src_q[0].d;
                tl = src_q[0].l;
            end else begin
                tv = 1'b0;
                tl = 1'b0;
            end
            #1;
            if (prev_stall) check("stall_hold", 32'({ivalid, idata}), 32'({1'b1, prev_data}));
            if (ivalid) check("busy_while_valid", 32'(dbusy), 32'd1);
            // With escaping on, an ESC byte in the slot means the escaped byte is still pending.
            if (!sel && ivalid && idata == ESC) check("esc2_tready", 32'(ttready), 32'd0);
            if (tv && ttready) begin
                if (first_pop < 0) first_pop = cyc;
                void'(src_q.pop_front());
            end
            if (ivalid && ir) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got_q.push_back(idata);
            end
            prev_stall = ivalid && !ir;
            prev_data  = idata;
            cyc++;
        end
        tv = 1'b0;
        tl = 1'b0;
        if (got_q.size() < limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d bytes, want %0d", got_q.size(), limit);
        end else if (rdy_mode == 0) begin
            check("start_latency", 32'(first_out), 32'd1);
            check("first_accept", 32'(first_pop), 32'd1);
            check("no_bubble", 32'(last_out - first_out + 1), 32'(limit));
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic post_check(input string tag);
        @(posedge aclk);
        #1;
        check({tag, "_busy_end"}, 32'(dbusy), 32'd0);
        check({tag, "_drained"}, 32'(ivalid), 32'd0);
        check({tag, "_frame_count"}, 32'(fcnt), 32'(exp_frm[sel] % 65536));
        check({tag, "_esc_count"}, 32'(ecnt), 32'(exp_esc[sel] % 65536));
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 0, 3, '{8'h01, 8'h02, 8'h03, 8'h00}, 4'b0100,
                    5, '{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1};
        vecs[1] = '{0, 0, 4, '{8'h7D, 8'h7E, 8'h7C, 8'h55}, 4'b1000,
                    9, '{8'h7D, 8'h7C, 8'h5D, 8'h7C, 8'h5E, 8'h7C, 8'h5C, 8'h55, 8'h7E, 8'h00}, 3, 1};
        vecs[2] = '{0, 1, 3, '{8'h01, 8'h02, 8'h03, 8'h00}, 4'b0100,
                    5, '{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1};
        vecs[3] = '{0, 0, 2, '{8'hAA, 8'h7E, 8'h00, 8'h00}, 4'b0011,
                    7, '{8'h7D, 8'hAA, 8'h7E, 8'h7D, 8'h7C, 8'h5E, 8'h7E, 8'h00, 8'h00, 8'h00}, 1, 2};
        vecs[4] = '{1, 0, 2, '{8'h7D, 8'h10, 8'h00, 8'h00}, 4'b0010,
                    4, '{8'h7D, 8'h7D, 8'h10, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1};
        vecs[5] = '{0, 2, 1, '{8'h7C, 8'h00, 8'h00, 8'h00}, 4'b0001,
                    4, '{8'h7D, 8'h7C, 8'h5C, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1};

        exp_frm = '{0, 0};
        exp_esc = '{0, 0};
        tv = 1'b0; tl = 1'b0; td = 8'h00; ir = 1'b1; sel = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 32'(d0_ivalid), 32'd0);
        check("rst_tdata", 32'(d0_idata), 32'd0);
        check("rst_frame_count", 32'(d0_fc), 32'd0);
        check("rst_esc_count", 32'(d0_ec), 32'd0);
        check("rst_busy", 32'(d0_busy), 32'd0);
        check("rst_tready", 32'(d0_tready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            sel = (vecs[v].sel != 0);
            src_q.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].n_in; i++) src_q.push_back('{vecs[v].din[i], vecs[v].lst[i]});
            for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(vecs[v].dout[i]);
            exp_esc[sel] += vecs[v].esc;
            exp_frm[sel] += vecs[v].frm;
            run_stream(vecs[v].rdy, vecs[v].n_out);
            compare_out($sformatf("vec%0d", v));
            post_check($sformatf("vec%0d", v));
        end

        // Random packets, expected bytes expanded directly from the framing rules.
        sel = 1'b0;
        src_q.delete();
        exp_q.delete();
        for (int p = 0; p < 15; p++) begin
            int len = $urandom_range(1, 6);
            exp_q.push_back(START);
            for (int j = 0; j < len; j++) begin
                logic [7:0] b = rand_byte();
                src_q.push_back('{b, (j == len - 1)});
                if (b == START || b == STOP || b == ESC) begin
                    exp_q.push_back(ESC);
                    exp_q.push_back(b ^ XORM);
                    exp_esc[0]++;
                end else begin
                    exp_q.push_back(b);
                end
            end
            exp_q.push_back(STOP);
            exp_frm[0]++;
        end
        run_stream(2, exp_q.size());
        compare_out("rand");
        post_check("rand");

        // Reset in the middle of a frame, after START and the first payload byte.
        sel = 1'b0;
        src_q.delete();
        src_q.push_back('{8'h01, 1'b0});
        src_q.push_back('{8'h02, 1'b0});
        src_q.push_back('{8'h03, 1'b0});
        src_q.push_back('{8'h04, 1'b1});
        run_stream(0, 2);
        if (got_q.size() == 2) begin
            check("midrst_b0", 32'(got_q[0]), 32'(START));
            check("midrst_b1", 32'(got_q[1]), 32'h01);
        end
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", 32'(d0_ivalid), 32'd0);
        check("midrst_frame_count", 32'(d0_fc), 32'd0);
        check("midrst_esc_count", 32'(d0_ec), 32'd0);
        check("midrst_busy", 32'(d0_busy), 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_frm = '{0, 0};
        exp_esc = '{0, 0};
        src_q.delete();
        exp_q.delete();
        src_q.push_back('{8'h09, 1'b1});
        exp_q.push_back(START);
        exp_q.push_back(8'h09);
        exp_q.push_back(STOP);
        exp_frm[0] = 1;
        run_stream(0, 3);
        compare_out("postrst");
        post_check("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
